// File: rtl/vga_pkg.sv
// Shared PS/2 scan-code constants and decoder state type for the keyboard front end.
package vga_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } kb_state_e;

  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_AA = 8'hAA;
  localparam logic [7:0] SC_FC = 8'hFC;
  localparam logic [7:0] SC_00 = 8'h00;
  localparam logic [7:0] SC_FF = 8'hFF;

  localparam logic [7:0] SC_W = 8'h1D;
  localparam logic [7:0] SC_S = 8'h1B;
  localparam logic [7:0] SC_D = 8'h23;
  localparam logic [7:0] SC_A = 8'h1C;

  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_LEFT  = 8'h6B;

  // BAT completion and keyboard error/overrun codes wipe all held keys.
  function automatic logic is_flush_code(input logic [7:0] code);
    return (code == SC_AA) || (code == SC_FC) || (code == SC_00) || (code == SC_FF);
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronises the raw lines, shifts in 11-bit frames and
// reports either a checked byte or a framing/parity/timeout error.
module ps2_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          clk_s1, clk_s2, clk_prev;
  logic          data_s1, data_s2;
  logic          sample;
  logic [3:0]    bit_cnt;
  logic [9:0]    shift;
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_s1     <= 1'b1;
      clk_s2     <= 1'b1;
      clk_prev   <= 1'b1;
      data_s1    <= 1'b1;
      data_s2    <= 1'b1;
      sample     <= 1'b0;
      bit_cnt    <= '0;
      shift      <= '0;
      to_cnt     <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      clk_s1     <= ps2_clk;
      clk_s2     <= clk_s1;
      data_s1    <= ps2_data;
      data_s2    <= data_s1;
      clk_prev   <= clk_s2;
      sample     <= clk_prev & ~clk_s2;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;

      if (sample) begin
        to_cnt <= '0;
        // Bits 0..9 are shifted in LSB-first; the stop bit is checked straight off the line.
        if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
          if (!shift[0] && data_s2 && (^shift[9:1])) begin
            rx_byte    <= shift[8:1];
            byte_valid <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          shift   <= {data_s2, shift[9:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if ((bit_cnt != 4'd0) && clk_s2) begin
        if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          bit_cnt   <= '0;
          to_cnt    <= '0;
          frame_err <= 1'b1;
        end else begin
          to_cnt <= to_cnt + TW'(1);
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/keyboard_ctl.sv
// Keyboard controller: turns PS/2 make/break codes into held-key levels for two
// players (WASD and arrow keys).
module keyboard_ctl
  import vga_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic p1_up,
  output logic p1_down,
  output logic p1_right,
  output logic p1_left,
  output logic p2_up,
  output logic p2_down,
  output logic p2_right,
  output logic p2_left,
  output logic frame_err
);

  logic [7:0] rx_byte;
  logic       byte_valid;
  kb_state_e  state;

  ps2_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      p1_up    <= 1'b0;
      p1_down  <= 1'b0;
      p1_right <= 1'b0;
      p1_left  <= 1'b0;
      p2_up    <= 1'b0;
      p2_down  <= 1'b0;
      p2_right <= 1'b0;
      p2_left  <= 1'b0;
    end else if (byte_valid) begin
      state <= ST_IDLE;
      if (is_flush_code(rx_byte)) begin
        p1_up    <= 1'b0;
        p1_down  <= 1'b0;
        p1_right <= 1'b0;
        p1_left  <= 1'b0;
        p2_up    <= 1'b0;
        p2_down  <= 1'b0;
        p2_right <= 1'b0;
        p2_left  <= 1'b0;
      end else begin
        // Codes from the wrong table for the current prefix fall to default: no change.
        case (state)
          ST_IDLE: begin
            if (rx_byte == SC_E0)      state <= ST_EXT;
            else if (rx_byte == SC_F0) state <= ST_BRK;
            else begin
              case (rx_byte)
                SC_W:    p1_up    <= 1'b1;
                SC_S:    p1_down  <= 1'b1;
                SC_D:    p1_right <= 1'b1;
                SC_A:    p1_left  <= 1'b1;
                default: ;
              endcase
            end
          end
          ST_BRK: begin
            case (rx_byte)
              SC_W:    p1_up    <= 1'b0;
              SC_S:    p1_down  <= 1'b0;
              SC_D:    p1_right <= 1'b0;
              SC_A:    p1_left  <= 1'b0;
              default: ;
            endcase
          end
          ST_EXT: begin
            if (rx_byte == SC_F0) state <= ST_EXT_BRK;
            else begin
              case (rx_byte)
                SC_UP:    p2_up    <= 1'b1;
                SC_DOWN:  p2_down  <= 1'b1;
                SC_RIGHT: p2_right <= 1'b1;
                SC_LEFT:  p2_left  <= 1'b1;
                default:  ;
              endcase
            end
          end
          ST_EXT_BRK: begin
            case (rx_byte)
              SC_UP:    p2_up    <= 1'b0;
              SC_DOWN:  p2_down  <= 1'b0;
              SC_RIGHT: p2_right <= 1'b0;
              SC_LEFT:  p2_left  <= 1'b0;
              default:  ;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keyboard_ctl.sv
// Scoreboard bench for keyboard_ctl: directed PS/2 frames push expected output
// events; a monitor compares every observed key change or frame_err pulse.
module tb_keyboard_ctl;

  localparam int unsigned TO   = 200;
  localparam int unsigned HALF = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic p1_up, p1_down, p1_right, p1_left;
  logic p2_up, p2_down, p2_right, p2_left;
  logic frame_err;

  keyboard_ctl #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .p1_up    (p1_up),
    .p1_down  (p1_down),
    .p1_right (p1_right),
    .p1_left  (p1_left),
    .p2_up    (p2_up),
    .p2_down  (p2_down),
    .p2_right (p2_right),
    .p2_left  (p2_left),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [8:0] val;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;
  logic mon_en = 1'b0;
  logic [7:0] prev_keys = '0;
  logic [7:0] cur_keys;

  // Key vector order: p1 up,down,right,left, p2 up,down,right,left.
  function automatic logic [7:0] keys();
    return {p1_up, p1_down, p1_right, p1_left, p2_up, p2_down, p2_right, p2_left};
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cur_keys = keys();
        if (frame_err || (cur_keys != prev_keys)) begin
          checks++;
          if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event got=%h expected=none", {frame_err, cur_keys});
          end else begin
            e = q.pop_front();
            if ({frame_err, cur_keys} !== e.val) begin
              failures++;
              $display("FAIL %s got=%h expected=%h", e.name, {frame_err, cur_keys}, e.val);
            end
          end
          prev_keys = cur_keys;
        end
      end
    end
  end

  task automatic push(input string name, input logic err, input logic [7:0] k);
    exp_t x;
    x.name = name;
    x.val  = {err, k};
    q.push_back(x);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b1;
    end
    repeat (HALF) @(posedge clk);
    ps2_data = 1'b1;
  endtask

  // kind 0: good frame, 1: even parity, 2: stop bit 0
  task automatic send_byte(input logic [7:0] d, input int unsigned kind);
    logic par;
    logic stp;
    par = (kind == 1) ? (^d) : ~(^d);
    stp = (kind == 2) ? 1'b0 : 1'b1;
    send_bits({stp, par, d, 1'b0}, 11);
    repeat (20) @(posedge clk);
  endtask

  task automatic drain(input string name, input int unsigned budget);
    for (int unsigned i = 0; i < budget && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout pending=%0d required=0", name, q.size());
      q.delete();
    end
  endtask

  initial begin
    rst = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (keys() !== 8'h00) begin
      failures++;
      $display("FAIL reset_keys got=%h expected=00", keys());
    end
    checks++;
    if (frame_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_frame_err got=%b expected=0", frame_err);
    end
    rst = 1'b1;
    mon_en = 1'b1;
    repeat (10) @(posedge clk);

    push("make_w", 0, 8'h80);        send_byte(8'h1D, 0); drain("make_w", 50);
    send_byte(8'hF0, 0);
    push("break_w", 0, 8'h00);       send_byte(8'h1D, 0); drain("break_w", 50);
    send_byte(8'hE0, 0);
    push("make_up", 0, 8'h08);       send_byte(8'h75, 0); drain("make_up", 50);
    push("make_w_both", 0, 8'h88);   send_byte(8'h1D, 0); drain("make_w_both", 50);
    send_byte(8'h1D, 0);
    send_byte(8'hE0, 0); send_byte(8'hF0, 0);
    push("break_up", 0, 8'h80);      send_byte(8'h75, 0); drain("break_up", 50);
    send_byte(8'hE0, 0); send_byte(8'h1D, 0);
    send_byte(8'h15, 0);
    push("parity_err", 1, 8'h80);    send_byte(8'h1C, 1); drain("parity_err", 50);
    push("make_a", 0, 8'h90);        send_byte(8'h1C, 0); drain("make_a", 50);
    push("stop_err", 1, 8'h90);      send_byte(8'h1B, 2); drain("stop_err", 50);

    push("timeout_err", 1, 8'h90);
    send_bits(11'b101_0010_0110, 5);
    drain("timeout_err", TO + 100);
    repeat (20) @(posedge clk);
    push("make_d", 0, 8'hB0);        send_byte(8'h23, 0); drain("make_d", 50);

    send_byte(8'hE0, 0);
    push("make_right", 0, 8'hB2);    send_byte(8'h74, 0); drain("make_right", 50);
    push("bat_clear", 0, 8'h00);     send_byte(8'hAA, 0); drain("bat_clear", 50);

    push("make_w2", 0, 8'h80);       send_byte(8'h1D, 0); drain("make_w2", 50);
    send_bits({1'b1, ~(^8'h1B), 8'h1B, 1'b0}, 6);
    push("reset_clear", 0, 8'h00);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    rst = 1'b1;
    drain("reset_clear", 10);
    repeat (TO + 50) @(posedge clk);
    push("make_s", 0, 8'h40);        send_byte(8'h1B, 0); drain("make_s", 50);
    repeat (50) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keyboard_ctl.md
KEYBOARD_CTL -- requirements
Module: keyboard_ctl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 100000, is the clk cycles with ps2_clk high mid-frame before the frame is aborted.
REQ-002 clk  input  1  system clock; all logic is on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-low (asserted when 0).
REQ-004 ps2_clk  input  1  raw PS/2 keyboard clock, asynchronous to clk.
REQ-005 ps2_data  input  1  raw PS/2 keyboard data, asynchronous to clk.
REQ-006 p1_up, p1_down, p1_right, p1_left  output  1 each  player-1 key held (W, S, D, A).
REQ-007 p2_up, p2_down, p2_right, p2_left  output  1 each  player-2 key held (arrow keys).
REQ-008 frame_err  output  1  one-cycle pulse on a parity, start/stop or timeout error.

Function
REQ-009 ps2_clk and ps2_data SHALL each pass through a 2-flop synchroniser before use.
REQ-010 A frame bit SHALL be sampled on the cycle after a synchronised ps2_clk 1->0 transition is detected.
REQ-011 A frame SHALL be 11 bits, LSB-first: start=0, 8 data bits, odd parity, stop=1.
REQ-012 The receiver SHALL pulse byte_valid for one cycle, one cycle after the stop-bit sample, only when start=0, stop=1 and odd parity all hold.
REQ-013 On any start, stop or parity failure the byte SHALL be dropped, frame_err SHALL pulse and the receiver SHALL return to idle.
REQ-014 If ps2_clk stays high for TIMEOUT_CYCLES consecutive cycles with 1-10 bits received, the partial frame SHALL be discarded and frame_err SHALL pulse.
REQ-015 The decoder FSM SHALL have states IDLE, EXT (after E0), BRK (after F0) and EXT_BRK (after E0 F0).
REQ-016 Transitions: IDLE--E0->EXT; IDLE--F0->BRK; EXT--F0->EXT_BRK; any other byte SHALL be a make or break code and return the FSM to IDLE.
REQ-017 Make/break mapping: IDLE/BRK 1D/1B/23/1C set/clear p1 up/down/right/left; EXT/EXT_BRK 75/72/74/6B set/clear p2 up/down/right/left.
REQ-018 Unmapped codes SHALL return the FSM to IDLE with no output change.
REQ-019 A non-extended code in an extended state, or the reverse, SHALL NOT alter any output.
REQ-020 Bytes AA (BAT), FC, 00 and FF (error/overrun) SHALL clear all eight key outputs and return the FSM to IDLE.
REQ-021 A key output SHALL change on the clock edge one cycle after the byte_valid pulse; outputs are registered levels.
REQ-022 Repeated make codes (typematic) SHALL leave the output at 1 without glitching.
REQ-023 Several keys MAY be held at once; the block does no arbitration, because the downstream draw stage applies up>down>right>left priority.
REQ-024 A frame error SHALL NOT change the FSM state or the key outputs.

Reset
REQ-025 While rst=0 at a rising clk edge: all key outputs 0, frame_err 0, FSM IDLE, receiver idle with bit count 0, timeout counter 0, synchroniser flops 1.
REQ-026 Reset mid-frame SHALL discard the partial frame; the first edge after release is treated as a new start bit.

Structure
REQ-027 vga_pkg SHALL hold the scan-code constants (E0, F0, AA, 1D, 1B, 23, 1C, 75, 72, 74, 6B) and the decoder state enum.
REQ-028 The frame receiver SHALL be sub-module ps2_rx (synchroniser, edge detect, shift register, parity, timeout), with outputs rx_byte[7:0], byte_valid and frame_err.
REQ-029 keyboard_ctl SHALL instantiate ps2_rx and hold only the decoder FSM and the eight key registers.
REQ-030 The outputs SHALL connect directly to the move_* inputs of draw_player_1 and draw_player_2.

Verification
REQ-031 Send frame 1D -> p1_up=1 one cycle after byte_valid; send F0 then 1D -> p1_up=0.
REQ-032 Send E0 75 then 1D -> p2_up=1 and p1_up=1 both held; send E0 F0 75 -> p2_up=0 and p1_up stays 1.
REQ-033 Send 1C with even parity -> frame_err pulses once, no output change, FSM stays IDLE; the next valid 1C sets p1_left.
REQ-034 Send 5 bits then hold ps2_clk high for TIMEOUT_CYCLES -> frame_err pulses; a following full frame 23 sets p1_right.
REQ-035 Hold 1D, 23, E0 74, then send AA -> all eight outputs 0.
REQ-036 Assert rst=0 after 6 bits of frame 1B, release, then send 1B -> p1_down=1, with no error from the partial frame.
